// File: rtl/video_timing_tx.sv
// Pixel-clock video timing generator: raster counters, active-area decode and a
// two-stage registered pipeline producing hs/vs/data_vld/RGB plus a pixel fetch port.
module video_timing_tx #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        en,
  output logic        pix_req,
  output logic [10:0] req_row,
  output logic [10:0] req_col,
  input  logic [23:0] pix_data,
  output logic        hs,
  output logic        vs,
  output logic        data_vld,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        frame_start,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_C = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_C = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_S  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_E  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_S  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_E  = 12'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
  logic        w_running, w_frame_end;
  logic        w_hs, w_vs, w_act, w_frame;
  logic [10:0] w_row, w_col;

  logic        r_s1_hs, r_s1_vs, r_s1_frame, r_pix_req;
  logic [10:0] r_req_row, r_req_col;
  logic        r_hs, r_vs, r_data_vld, r_frame_start;
  logic [23:0] r_rgb;

  assign w_running   = (r_state != ST_IDLE);
  assign w_frame_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

  // Leaving RUN only ever passes through DRAIN, which exits to IDLE solely on the
  // last position of a frame, so a started frame is never cut short.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!en) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_frame_end) w_state_nxt = en ? ST_RUN : ST_IDLE;
        else if (en)     w_state_nxt = ST_RUN;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_h_nxt = 12'd0;
    w_v_nxt = 12'd0;
    if (w_running && (w_state_nxt != ST_IDLE)) begin
      w_h_nxt = (r_h_cnt == H_LAST) ? 12'd0 : r_h_cnt + 12'd1;
      w_v_nxt = r_v_cnt;
      if (r_h_cnt == H_LAST) w_v_nxt = (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
    end
  end

  // Stage-0 decode; IDLE forces the blanking values into the pipeline.
  assign w_hs    = !(w_running && (r_h_cnt < H_SYNC_C));
  assign w_vs    = !(w_running && (r_v_cnt < V_SYNC_C));
  assign w_act   = w_running && (r_h_cnt >= H_ACT_S) && (r_h_cnt < H_ACT_E)
                             && (r_v_cnt >= V_ACT_S) && (r_v_cnt < V_ACT_E);
  assign w_frame = w_running && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
  assign w_col   = 11'(r_h_cnt - H_ACT_S);
  assign w_row   = 11'(r_v_cnt - V_ACT_S);

  // Fetch protocol: pix_req is a one-cycle strobe with no back-pressure; the source
  // must present pix_data for that request by the clock edge that ends the strobe
  // cycle, where stage 2 captures it.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      r_state       <= ST_IDLE;
      r_h_cnt       <= 12'd0;
      r_v_cnt       <= 12'd0;
      r_s1_hs       <= 1'b1;
      r_s1_vs       <= 1'b1;
      r_s1_frame    <= 1'b0;
      r_pix_req     <= 1'b0;
      r_req_row     <= 11'd0;
      r_req_col     <= 11'd0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_data_vld    <= 1'b0;
      r_frame_start <= 1'b0;
      r_rgb         <= 24'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_h_cnt    <= w_h_nxt;
      r_v_cnt    <= w_v_nxt;
      r_s1_hs    <= w_hs;
      r_s1_vs    <= w_vs;
      r_s1_frame <= w_frame;
      r_pix_req  <= w_act;
      if (w_act) begin
        r_req_row <= w_row;
        r_req_col <= w_col;
      end
      r_hs          <= r_s1_hs;
      r_vs          <= r_s1_vs;
      r_data_vld    <= r_pix_req;
      r_frame_start <= r_s1_frame;
      r_rgb         <= r_pix_req ? pix_data : 24'd0;
    end
  end

  assign pix_req     = r_pix_req;
  assign req_row     = r_req_row;
  assign req_col     = r_req_col;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign data_vld    = r_data_vld;
  assign frame_start = r_frame_start;
  assign R           = r_rgb[23:16];
  assign G           = r_rgb[15:8];
  assign B           = r_rgb[7:0];
  assign busy        = w_running;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_video_timing_tx.sv
// Directed bench for video_timing_tx on an 8x6 raster (48 cycles per frame).
module tb_video_timing_tx;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        en = 1'b0;
  logic        pix_req, hs, vs, data_vld, frame_start, busy;
  logic [10:0] req_row, req_col;
  logic [23:0] pix_data;
  logic [7:0]  r_o, g_o, b_o;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Upstream source returns its own request coordinates as the pixel value.
  assign pix_data = {2'b00, req_row, req_col};

  video_timing_tx #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .pixel_clk(clk), .sys_rst(sys_rst), .en(en),
    .pix_req(pix_req), .req_row(req_row), .req_col(req_col), .pix_data(pix_data),
    .hs(hs), .vs(vs), .data_vld(data_vld), .R(r_o), .G(g_o), .B(b_o),
    .frame_start(frame_start), .busy(busy), .dbg_state(dbg_state)
  );

  // Raster model: position p counts cycles from the frame origin.
  function automatic logic exp_act(input int p);
    int h, v;
    h = p % 8;
    v = (p / 8) % 6;
    return (h >= 3) && (h < 7) && (v >= 2) && (v < 5);
  endfunction

  function automatic logic exp_hs(input int p);
    return (p % 8) >= 2;
  endfunction

  function automatic logic exp_vs(input int p);
    return ((p / 8) % 6) >= 1;
  endfunction

  function automatic logic [10:0] exp_row(input int p);
    return 11'(((p / 8) % 6) - 2);
  endfunction

  function automatic logic [10:0] exp_col(input int p);
    return 11'((p % 8) - 3);
  endfunction

  function automatic logic [23:0] exp_rgb(input int p);
    if (!exp_act(p)) return 24'd0;
    return {2'b00, exp_row(p), exp_col(p)};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    sys_rst = 1'b1;
    en      = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic start_run(output bit found, output int lat);
    en    = 1'b1;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    sys_rst = 1'b1;
    en      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({hs, vs, data_vld, frame_start, busy, pix_req} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_ctrl got hs,vs,vld,fs,busy,req=%b expected 110000",
               {hs, vs, data_vld, frame_start, busy, pix_req});
    end
    n_checks++;
    if ({r_o, g_o, b_o} !== 24'd0 || req_row !== 11'd0 || req_col !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_data got rgb=%h row=%0d col=%0d expected 0/0/0",
               {r_o, g_o, b_o}, req_row, req_col);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d expected 0", dbg_state);
    end
    sys_rst = 1'b0;
    en      = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hs !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_hold got busy=%b hs=%b expected 0/1", busy, hs);
    end
  endtask

  task automatic test_stream();
    bit found;
    int lat, req_cnt;
    logic [10:0] last_row, last_col;
    apply_reset();
    start_run(found, lat);
    n_checks++;
    if (!found || lat != 3) begin
      n_fail++;
      $display("FAIL start_latency got found=%0d lat=%0d expected 1/3", found, lat);
    end
    last_row = 11'd0;
    last_col = 11'd0;
    req_cnt  = 0;
    for (int p = 0; p < 144; p++) begin
      if (p > 0) @(negedge clk);
      n_checks++;
      if (hs !== exp_hs(p) || vs !== exp_vs(p)) begin
        n_fail++;
        $display("FAIL stream_sync p=%0d got hs=%b vs=%b expected %b/%b",
                 p, hs, vs, exp_hs(p), exp_vs(p));
      end
      n_checks++;
      if (data_vld !== exp_act(p) || frame_start !== ((p % 48) == 0) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_flags p=%0d got vld=%b fs=%b busy=%b expected %b/%b/1",
                 p, data_vld, frame_start, busy, exp_act(p), (p % 48) == 0);
      end
      n_checks++;
      if ({r_o, g_o, b_o} !== exp_rgb(p)) begin
        n_fail++;
        $display("FAIL stream_rgb p=%0d got %h expected %h", p, {r_o, g_o, b_o}, exp_rgb(p));
      end
      if (exp_act(p + 1)) begin
        last_row = exp_row(p + 1);
        last_col = exp_col(p + 1);
      end
      n_checks++;
      if (pix_req !== exp_act(p + 1) || req_row !== last_row || req_col !== last_col) begin
        n_fail++;
        $display("FAIL stream_req p=%0d got req=%b row=%0d col=%0d expected %b/%0d/%0d",
                 p, pix_req, req_row, req_col, exp_act(p + 1), last_row, last_col);
      end
      if (pix_req === 1'b1) req_cnt++;
      if ((p % 48) == 47) begin
        n_checks++;
        if (req_cnt != 12) begin
          n_fail++;
          $display("FAIL req_per_frame p=%0d got %0d expected 12", p, req_cnt);
        end
        req_cnt = 0;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_drain();
    bit found;
    int lat;
    logic e_hs, e_vs, e_vld, e_req;
    logic [10:0] last_row, last_col;
    apply_reset();
    start_run(found, lat);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL drain_start got no frame_start expected one within 10 cycles");
    end
    last_row = 11'd0;
    last_col = 11'd0;
    for (int p = 0; p < 64; p++) begin
      if (p > 0) @(negedge clk);
      e_hs  = (p < 48) ? exp_hs(p) : 1'b1;
      e_vs  = (p < 48) ? exp_vs(p) : 1'b1;
      e_vld = (p < 48) ? exp_act(p) : 1'b0;
      e_req = (p + 1 < 48) ? exp_act(p + 1) : 1'b0;
      if (e_req) begin
        last_row = exp_row(p + 1);
        last_col = exp_col(p + 1);
      end
      n_checks++;
      if (hs !== e_hs || vs !== e_vs || data_vld !== e_vld || busy !== (p < 46)
          || frame_start !== (p == 0)) begin
        n_fail++;
        $display("FAIL drain_ctrl p=%0d got hs=%b vs=%b vld=%b busy=%b fs=%b expected %b/%b/%b/%b/%b",
                 p, hs, vs, data_vld, busy, frame_start, e_hs, e_vs, e_vld, p < 46, p == 0);
      end
      n_checks++;
      if (pix_req !== e_req || req_row !== last_row || req_col !== last_col) begin
        n_fail++;
        $display("FAIL drain_req p=%0d got req=%b row=%0d col=%0d expected %b/%0d/%0d",
                 p, pix_req, req_row, req_col, e_req, last_row, last_col);
      end
      if (p == 20) en = 1'b0;
    end
  endtask

  task automatic test_reenable();
    bit found;
    int lat;
    apply_reset();
    start_run(found, lat);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reen_start got no frame_start expected one within 10 cycles");
    end
    for (int p = 0; p < 100; p++) begin
      if (p > 0) @(negedge clk);
      n_checks++;
      if (hs !== exp_hs(p) || vs !== exp_vs(p) || data_vld !== exp_act(p)
          || frame_start !== ((p % 48) == 0) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reen_ctrl p=%0d got hs=%b vs=%b vld=%b fs=%b busy=%b expected %b/%b/%b/%b/1",
                 p, hs, vs, data_vld, frame_start, busy,
                 exp_hs(p), exp_vs(p), exp_act(p), (p % 48) == 0);
      end
      n_checks++;
      if ({r_o, g_o, b_o} !== exp_rgb(p)) begin
        n_fail++;
        $display("FAIL reen_rgb p=%0d got %h expected %h", p, {r_o, g_o, b_o}, exp_rgb(p));
      end
      if (p == 20) en = 1'b0;
      if (p == 30) en = 1'b1;
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int lat;
    apply_reset();
    start_run(found, lat);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rstmid_start got no frame_start expected one within 10 cycles");
    end
    repeat (25) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({hs, vs, data_vld, frame_start, busy, pix_req} !== 6'b110000
        || {r_o, g_o, b_o} !== 24'd0 || req_row !== 11'd0 || req_col !== 11'd0) begin
      n_fail++;
      $display("FAIL rstmid_values got ctrl=%b rgb=%h row=%0d col=%0d expected 110000/0/0/0",
               {hs, vs, data_vld, frame_start, busy, pix_req}, {r_o, g_o, b_o}, req_row, req_col);
    end
    sys_rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (frame_start !== (k == 3) || hs !== (k != 3) || vs !== (k != 3)
          || busy !== 1'b1 || data_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_restart k=%0d got fs=%b hs=%b vs=%b busy=%b vld=%b expected %b/%b/%b/1/0",
                 k, frame_start, hs, vs, busy, data_vld, k == 3, k != 3, k != 3);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_drain();
    test_reenable();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
